// File: rtl/gpio_in_cond.sv
`default_nettype none
// ============================================================================
// Module   : gpio_in_cond
// Purpose  : Input conditioning in front of the Wishbone GPIO register block.
//            Raw pad inputs are synchronised to clk_sys_i, then debounced
//            per channel against a runtime threshold. Produces the clean
//            level vector and registered one-cycle rise/fall pulses.
//            Optional sticky event latches plus an interrupt line are built
//            only when GPIO_IN_COND_EVT_EN is defined.
// Ports    : clk_sys_i      system clock (rising edge)
//            rst_i          synchronous active-high reset
//            pad_in_i       raw asynchronous pad inputs [WIDTH]
//            deb_cycles_i   debounce threshold, quasi-static [DEB_CNT_W]
//            gpio_in_o      debounced stable level [WIDTH]
//            rise_o/fall_o  one-cycle pulses on gpio_in_o edges [WIDTH]
//            evt_rise_en_i  rising-event latch enable [WIDTH]
//            evt_fall_en_i  falling-event latch enable [WIDTH]
//            evt_clr_i      pending clear strobe [WIDTH]
//            pending_o      sticky event flags [WIDTH]
//            irq_o          OR of pending_o
// Params   : WIDTH (8), SYNC_STAGES (2, legal 2..4), DEB_CNT_W (16)
// Macro    : GPIO_IN_COND_EVT_EN enables the event latches and irq_o;
//            undefined ties pending_o/irq_o to 0.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_in_cond #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CNT_W   = 16
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     pad_in_i,
  input  logic [DEB_CNT_W-1:0] deb_cycles_i,
  output logic [WIDTH-1:0]     gpio_in_o,
  output logic [WIDTH-1:0]     rise_o,
  output logic [WIDTH-1:0]     fall_o,
  input  logic [WIDTH-1:0]     evt_rise_en_i,
  input  logic [WIDTH-1:0]     evt_fall_en_i,
  input  logic [WIDTH-1:0]     evt_clr_i,
  output logic [WIDTH-1:0]     pending_o,
  output logic                 irq_o
);

  localparam logic [DEB_CNT_W-1:0] c_cnt_one = DEB_CNT_W'(1);

  // Synchroniser chain; stage SYNC_STAGES-1 is the only sampled output.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_sync;

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= pad_in_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [DEB_CNT_W-1:0] r_cnt;
      logic                 r_level;
      logic                 r_rise;
      logic                 r_fall;

      // The count only advances while cnt < threshold, so it can never wrap.
      // A lowered threshold below the running count commits on the next
      // compare because the test is ">=" rather than "==".
      always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
          r_cnt   <= '0;
          r_level <= 1'b0;
          r_rise  <= 1'b0;
          r_fall  <= 1'b0;
        end else begin
          r_rise <= 1'b0;
          r_fall <= 1'b0;
          if (w_sync[gi] == r_level) begin
            r_cnt <= '0;
          end else if (r_cnt >= deb_cycles_i) begin
            r_level <= w_sync[gi];
            r_cnt   <= '0;
            r_rise  <= w_sync[gi];
            r_fall  <= ~w_sync[gi];
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
      end

      assign gpio_in_o[gi] = r_level;
      assign rise_o[gi]    = r_rise;
      assign fall_o[gi]    = r_fall;

`ifdef GPIO_IN_COND_EVT_EN
      logic r_pend;

      // Set has priority over a coincident clear so no event is lost.
      always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
          r_pend <= 1'b0;
        end else if ((r_rise & evt_rise_en_i[gi]) | (r_fall & evt_fall_en_i[gi])) begin
          r_pend <= 1'b1;
        end else if (evt_clr_i[gi]) begin
          r_pend <= 1'b0;
        end
      end

      assign pending_o[gi] = r_pend;
`else
      assign pending_o[gi] = 1'b0;
`endif
    end : g_chan
  endgenerate

`ifdef GPIO_IN_COND_EVT_EN
  assign irq_o = |pending_o;
`else
  // Event inputs are intentionally ignored in this build.
  logic w_evt_unused;
  assign w_evt_unused = ^{evt_rise_en_i, evt_fall_en_i, evt_clr_i};
  assign irq_o        = 1'b0;
`endif

endmodule : gpio_in_cond
`default_nettype wire

// File: tb/tb_gpio_in_cond.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_in_cond
// Purpose  : Self-checking bench for gpio_in_cond. Expected output vectors
//            are derived from the documented latency rules and queued when
//            stimulus is applied, then popped and compared cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_in_cond;

  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int DEB_CNT_W   = 16;

`ifdef GPIO_IN_COND_EVT_EN
  localparam bit EVT = 1'b1;
`else
  localparam bit EVT = 1'b0;
`endif

  logic                 clk_sys_i = 1'b0;
  logic                 rst_i;
  logic [WIDTH-1:0]     pad_in_i;
  logic [DEB_CNT_W-1:0] deb_cycles_i;
  logic [WIDTH-1:0]     gpio_in_o;
  logic [WIDTH-1:0]     rise_o;
  logic [WIDTH-1:0]     fall_o;
  logic [WIDTH-1:0]     evt_rise_en_i;
  logic [WIDTH-1:0]     evt_fall_en_i;
  logic [WIDTH-1:0]     evt_clr_i;
  logic [WIDTH-1:0]     pending_o;
  logic                 irq_o;

  gpio_in_cond #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CNT_W   (DEB_CNT_W)
  ) dut (
    .clk_sys_i     (clk_sys_i),
    .rst_i         (rst_i),
    .pad_in_i      (pad_in_i),
    .deb_cycles_i  (deb_cycles_i),
    .gpio_in_o     (gpio_in_o),
    .rise_o        (rise_o),
    .fall_o        (fall_o),
    .evt_rise_en_i (evt_rise_en_i),
    .evt_fall_en_i (evt_fall_en_i),
    .evt_clr_i     (evt_clr_i),
    .pending_o     (pending_o),
    .irq_o         (irq_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  typedef struct {
    int         cyc;
    logic [7:0] gpio;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] pend;
    logic       irq;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge clk_sys_i);
    #1;
  endtask

  task automatic push(input int cyc, input logic [7:0] g, input logic [7:0] r,
                      input logic [7:0] f, input logic [7:0] p, input logic q);
    exp_t e;
    e.cyc = cyc; e.gpio = g; e.rise = r; e.fall = f; e.pend = p; e.irq = q;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    pad_in_i = '0; evt_rise_en_i = '0; evt_fall_en_i = '0; evt_clr_i = '0;
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    sb.delete();
    repeat (4) tick();
  endtask

  function automatic bit zt_pad(int t);
    return (t >= 0) && (t < 16) && ((t / 4) % 2 == 0);
  endfunction

  function automatic bit ev_pad(int t);
    return (t >= 0) && ((t < 5) || (t >= 10));
  endfunction

  // Reset values, then a pad held high through reset rises 6 cycles later.
  task automatic test_reset();
    exp_t e;
    rst_i = 1'b1; pad_in_i = 8'hFF; deb_cycles_i = 16'd3;
    evt_rise_en_i = 8'hFF; evt_fall_en_i = 8'hFF; evt_clr_i = '0;
    tick();
    n_checks++; if (gpio_in_o !== 8'h00) begin n_fail++; $display("FAIL reset_gpio got %h exp 00", gpio_in_o); end
    n_checks++; if (rise_o !== 8'h00) begin n_fail++; $display("FAIL reset_rise got %h exp 00", rise_o); end
    n_checks++; if (fall_o !== 8'h00) begin n_fail++; $display("FAIL reset_fall got %h exp 00", fall_o); end
    n_checks++; if (pending_o !== 8'h00) begin n_fail++; $display("FAIL reset_pend got %h exp 00", pending_o); end
    n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", irq_o); end
    rst_i = 1'b0;
    for (int c = 1; c <= 9; c++)
      push(c, (c >= 6) ? 8'hFF : 8'h00, (c == 6) ? 8'hFF : 8'h00, 8'h00,
           (EVT && c >= 7) ? 8'hFF : 8'h00, EVT && c >= 7);
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); n_checks++;
        if ({gpio_in_o, rise_o, fall_o, pending_o, irq_o} !== {e.gpio, e.rise, e.fall, e.pend, e.irq}) begin
          n_fail++;
          $display("FAIL reset_hold c=%0d got %h/%h/%h/%h/%b exp %h/%h/%h/%h/%b", c,
                   gpio_in_o, rise_o, fall_o, pending_o, irq_o, e.gpio, e.rise, e.fall, e.pend, e.irq);
        end
      end
    end
  endtask

  task automatic test_clean_rise();
    exp_t e;
    do_reset();
    deb_cycles_i = 16'd3;
    for (int c = 1; c <= 16; c++)
      push(c, (c >= 6 && c < 14) ? 8'h01 : 8'h00, (c == 6) ? 8'h01 : 8'h00,
           (c == 14) ? 8'h01 : 8'h00, 8'h00, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      pad_in_i[0] = (c - 1 < 8);
      tick();
      if (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); n_checks++;
        if ({gpio_in_o, rise_o, fall_o, pending_o, irq_o} !== {e.gpio, e.rise, e.fall, e.pend, e.irq}) begin
          n_fail++;
          $display("FAIL clean_rise c=%0d got %h/%h/%h/%h/%b exp %h/%h/%h/%h/%b", c,
                   gpio_in_o, rise_o, fall_o, pending_o, irq_o, e.gpio, e.rise, e.fall, e.pend, e.irq);
        end
      end
    end
  endtask

  // 4-cycle glitch rejected, then a 6-cycle pulse accepted (deb=5).
  task automatic test_glitch();
    exp_t e;
    do_reset();
    deb_cycles_i = 16'd5;
    for (int c = 1; c <= 30; c++)
      push(c, (c >= 20 && c < 26) ? 8'h04 : 8'h00, (c == 20) ? 8'h04 : 8'h00,
           (c == 26) ? 8'h04 : 8'h00, 8'h00, 1'b0);
    for (int c = 1; c <= 30; c++) begin
      pad_in_i[2] = ((c - 1) < 4) || ((c - 1) >= 12 && (c - 1) < 18);
      tick();
      if (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); n_checks++;
        if ({gpio_in_o, rise_o, fall_o, pending_o, irq_o} !== {e.gpio, e.rise, e.fall, e.pend, e.irq}) begin
          n_fail++;
          $display("FAIL glitch c=%0d got %h/%h/%h/%h/%b exp %h/%h/%h/%h/%b", c,
                   gpio_in_o, rise_o, fall_o, pending_o, irq_o, e.gpio, e.rise, e.fall, e.pend, e.irq);
        end
      end
    end
  endtask

  // deb=0: channel 7 follows the pad with a fixed 3-cycle latency.
  task automatic test_zero_thresh();
    exp_t e;
    bit   now, prev;
    do_reset();
    deb_cycles_i = 16'd0;
    for (int c = 1; c <= 22; c++) begin
      now  = zt_pad(c - 3);
      prev = zt_pad(c - 4);
      push(c, {now, 7'b0}, {now & ~prev, 7'b0}, {~now & prev, 7'b0}, 8'h00, 1'b0);
    end
    for (int c = 1; c <= 22; c++) begin
      pad_in_i[7] = zt_pad(c - 1);
      tick();
      if (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); n_checks++;
        if ({gpio_in_o, rise_o, fall_o, pending_o, irq_o} !== {e.gpio, e.rise, e.fall, e.pend, e.irq}) begin
          n_fail++;
          $display("FAIL zero_thresh c=%0d got %h/%h/%h/%h/%b exp %h/%h/%h/%h/%b", c,
                   gpio_in_o, rise_o, fall_o, pending_o, irq_o, e.gpio, e.rise, e.fall, e.pend, e.irq);
        end
      end
    end
  endtask

  // cnt reaches 10 with deb=20; dropping deb to 2 commits on the next edge.
  task automatic test_thresh_change();
    exp_t e;
    do_reset();
    deb_cycles_i = 16'd20;
    for (int c = 1; c <= 24; c++)
      push(c, (c >= 13 && c < 21) ? 8'h08 : 8'h00, (c == 13) ? 8'h08 : 8'h00,
           (c == 21) ? 8'h08 : 8'h00, 8'h00, 1'b0);
    for (int c = 1; c <= 24; c++) begin
      pad_in_i[3] = (c - 1 < 16);
      if (c - 1 == 12) deb_cycles_i = 16'd2;
      tick();
      if (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); n_checks++;
        if ({gpio_in_o, rise_o, fall_o, pending_o, irq_o} !== {e.gpio, e.rise, e.fall, e.pend, e.irq}) begin
          n_fail++;
          $display("FAIL thresh_change c=%0d got %h/%h/%h/%h/%b exp %h/%h/%h/%h/%b", c,
                   gpio_in_o, rise_o, fall_o, pending_o, irq_o, e.gpio, e.rise, e.fall, e.pend, e.irq);
        end
      end
    end
  endtask

  // Maximum threshold: the step commits exactly 65538 cycles later.
  task automatic test_saturation();
    exp_t e;
    do_reset();
    deb_cycles_i = 16'hFFFF;
    push(1,     8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    push(65537, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    push(65538, 8'h10, 8'h10, 8'h00, 8'h00, 1'b0);
    push(65539, 8'h10, 8'h00, 8'h00, 8'h00, 1'b0);
    pad_in_i[4] = 1'b1;
    for (int c = 1; c <= 65539; c++) begin
      tick();
      if (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); n_checks++;
        if ({gpio_in_o, rise_o, fall_o, pending_o, irq_o} !== {e.gpio, e.rise, e.fall, e.pend, e.irq}) begin
          n_fail++;
          $display("FAIL saturation c=%0d got %h/%h/%h/%h/%b exp %h/%h/%h/%h/%b", c,
                   gpio_in_o, rise_o, fall_o, pending_o, irq_o, e.gpio, e.rise, e.fall, e.pend, e.irq);
        end
      end
    end
  endtask

  // Reset while ch1 counts (cnt=4) and ch5 is already high with a pending flag.
  task automatic test_reset_mid();
    exp_t e;
    logic [7:0] g, p;
    do_reset();
    deb_cycles_i = 16'd0;
    evt_rise_en_i = 8'hFF;
    for (int c = 1; c <= 18; c++) begin
      g = 8'h00;
      if (c >= 3 && c <= 9) g = 8'h20;
      if (c >= 16) g = 8'h22;
      p = 8'h00;
      if (EVT && c >= 4 && c <= 9) p = 8'h20;
      if (EVT && c >= 17) p = 8'h22;
      push(c, g, (c == 3) ? 8'h20 : ((c == 16) ? 8'h22 : 8'h00), 8'h00, p, |p);
    end
    for (int c = 1; c <= 18; c++) begin
      pad_in_i[5] = 1'b1;
      if (c - 1 == 3) begin deb_cycles_i = 16'd10; pad_in_i[1] = 1'b1; end
      if (c - 1 == 9) begin rst_i = 1'b1; deb_cycles_i = 16'd3; end
      if (c - 1 == 10) rst_i = 1'b0;
      tick();
      if (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); n_checks++;
        if ({gpio_in_o, rise_o, fall_o, pending_o, irq_o} !== {e.gpio, e.rise, e.fall, e.pend, e.irq}) begin
          n_fail++;
          $display("FAIL reset_mid c=%0d got %h/%h/%h/%h/%b exp %h/%h/%h/%h/%b", c,
                   gpio_in_o, rise_o, fall_o, pending_o, irq_o, e.gpio, e.rise, e.fall, e.pend, e.irq);
        end
      end
    end
  endtask

  // Sticky flag, set-wins-over-clear, plain clear; all-zero when not built.
  task automatic test_events();
    exp_t e;
    bit   now, prev, pd;
    do_reset();
    deb_cycles_i  = 16'd0;
    evt_rise_en_i = 8'h01;
    for (int c = 1; c <= 20; c++) begin
      now  = ev_pad(c - 3);
      prev = ev_pad(c - 4);
      pd   = EVT && (c >= 4) && (c < 17);
      push(c, {7'b0, now}, {7'b0, now & ~prev}, {7'b0, ~now & prev}, {7'b0, pd}, pd);
    end
    for (int c = 1; c <= 20; c++) begin
      pad_in_i[0] = ev_pad(c - 1);
      if (c - 1 == 6)  evt_rise_en_i = 8'h00;
      if (c - 1 == 10) evt_rise_en_i = 8'h01;
      evt_clr_i = (c - 1 == 13 || c - 1 == 16) ? 8'h01 : 8'h00;
      tick();
      if (sb.size() != 0 && sb[0].cyc == c) begin
        e = sb.pop_front(); n_checks++;
        if ({gpio_in_o, rise_o, fall_o, pending_o, irq_o} !== {e.gpio, e.rise, e.fall, e.pend, e.irq}) begin
          n_fail++;
          $display("FAIL events c=%0d got %h/%h/%h/%h/%b exp %h/%h/%h/%h/%b", c,
                   gpio_in_o, rise_o, fall_o, pending_o, irq_o, e.gpio, e.rise, e.fall, e.pend, e.irq);
        end
      end
    end
    evt_clr_i = '0;
  endtask

  initial begin
    rst_i = 1'b1; pad_in_i = '0; deb_cycles_i = '0;
    evt_rise_en_i = '0; evt_fall_en_i = '0; evt_clr_i = '0;
    test_reset();
    test_clean_rise();
    test_glitch();
    test_zero_thresh();
    test_thresh_change();
    test_reset_mid();
    test_events();
    test_saturation();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d entries exp 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule : tb_gpio_in_cond
`default_nettype wire

// File: doc/gpio_in_cond.md
Name: gpio_in_cond

Overview:
- Input-conditioning stage directly upstream of the Wishbone GPIO register block.
- Takes raw asynchronous pad inputs, synchronises them to clk_sys_i, and debounces each channel with a runtime-programmable threshold.
- Produces the clean level vector that drives the GPIO block's gpio_in_i, plus single-cycle rise/fall pulses.
- Optionally provides sticky per-channel event latches and an interrupt line.

Parameters:
- WIDTH, 8: number of GPIO channels.
- SYNC_STAGES, 2: synchroniser depth; legal range 2..4.
- DEB_CNT_W, 16: width of the per-channel debounce counter and of deb_cycles_i.

Ports:
- clk_sys_i  input  1  system clock; every flop in the block is on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- pad_in_i  input  WIDTH  raw asynchronous pad inputs.
- deb_cycles_i  input  DEB_CNT_W  debounce threshold from the register block; quasi-static.
- gpio_in_o  output  WIDTH  debounced stable level; connects to the GPIO block's gpio_in_i.
- rise_o  output  WIDTH  one-cycle pulse on a 0->1 transition of gpio_in_o.
- fall_o  output  WIDTH  one-cycle pulse on a 1->0 transition of gpio_in_o.
- evt_rise_en_i  input  WIDTH  per-channel rising-event latch enable.
- evt_fall_en_i  input  WIDTH  per-channel falling-event latch enable.
- evt_clr_i  input  WIDTH  per-channel pending clear, one-cycle strobe.
- pending_o  output  WIDTH  sticky event flags.
- irq_o  output  1  OR of pending_o.

Behaviour:
- Interface: one clock, clk_sys_i. Reset rst_i is synchronous and active-high.
- Reset: all synchroniser flops, gpio_in_o, counters, rise_o, fall_o and pending_o clear to 0; irq_o = 0.
- Synchroniser: SYNC_STAGES-flop chain per channel. sync[i] is the last stage. No other logic samples pad_in_i.
- Debounce, per channel, each cycle:
  - If sync[i] == gpio_in_o[i]: cnt <= 0.
  - Else if cnt >= deb_cycles_i: gpio_in_o[i] <= sync[i]; cnt <= 0.
  - Else: cnt <= cnt + 1.
- Counter range: cnt never exceeds deb_cycles_i, so it cannot overflow, including at deb_cycles_i = 2^DEB_CNT_W-1.
- Glitch rejection: any return of sync[i] to the stable value before the threshold restarts the count from 0.
- Latency: a pad step held steady reaches gpio_in_o exactly SYNC_STAGES + deb_cycles_i + 1 cycles after the first sampling edge.
  - deb_cycles_i = 0 means no filtering; latency is SYNC_STAGES + 1.
- Threshold change mid-count: takes effect on the next compare. Lowering the threshold below the current cnt commits the update on the next cycle.
- Edge pulses: rise_o[i] / fall_o[i] are registered and assert in the same cycle gpio_in_o[i] changes, for exactly one cycle.
  - Channels are independent; several may pulse together.
  - Back-to-back transitions on one channel are at least deb_cycles_i + 1 cycles apart.
- After reset the stable value is 0. A pad held high through reset therefore produces one rise_o pulse SYNC_STAGES + deb_cycles_i + 1 cycles after rst_i deasserts. This is intended; software clears the resulting pending flag.
- Reset mid-debounce: cnt is discarded. The count restarts from 0 after reset deasserts.

Optional Feature:
- Macro: GPIO_IN_COND_EVT_EN.
- Defined:
  - pending_o[i] <= 1 in the cycle after (rise_o[i] & evt_rise_en_i[i]) | (fall_o[i] & evt_fall_en_i[i]).
  - pending_o[i] is otherwise held until evt_clr_i[i].
  - A set and a clear arriving in the same cycle: set wins.
  - irq_o is the combinational OR of pending_o.
  - Changing an enable affects only future pulses; it never clears an existing flag.
- Undefined: pending_o and irq_o are tied to 0; evt_*_i inputs are ignored; no event flops are generated.
- gpio_in_o, rise_o and fall_o behave identically in both builds.

Test Plan:
- Clean rise: SYNC_STAGES=2, deb_cycles_i=3, pad_in_i[0] 0->1 held.
  - gpio_in_o[0] rises exactly 6 cycles after the first sampling edge.
  - rise_o[0] is high for that one cycle only.
- Glitch rejection: deb_cycles_i=5; pad_in_i[2] high for 4 cycles (as seen at sync), then low.
  - gpio_in_o[2] stays 0 and rise_o[2] never asserts.
  - A subsequent 6-cycle-high pulse is accepted.
- Zero threshold: deb_cycles_i=0; toggle pad_in_i[7] every 4 cycles.
  - gpio_in_o[7] follows with 3-cycle latency.
  - rise_o and fall_o alternate, one pulse per edge.
- Saturation and threshold change:
  - deb_cycles_i=16'hFFFF: a held step commits after 65538 cycles.
  - Separately, with cnt=10, lower deb_cycles_i to 2: the update commits next cycle.
- Reset mid-operation: pulse rst_i while cnt=4 and pad_in_i[1]=1.
  - All outputs read 0 in the cycle after the reset edge.
  - With deb_cycles_i=3, gpio_in_o[1] rises 6 cycles after rst_i deasserts.
- Events (GPIO_IN_COND_EVT_EN defined): evt_rise_en_i=8'h01, rise on ch0.
  - pending_o=8'h01 and irq_o=1 one cycle after rise_o.
  - evt_clr_i=8'h01 coincident with a new enabled rise leaves pending_o=8'h01.
  - A clear alone gives pending_o=0 and irq_o=0.
  - With the macro undefined, pending_o stays 0 throughout.
